// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// default bit period used by both the transmitter and receiver cores.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 87;  // 10 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Serial input conditioning: 2-FF synchroniser, 3-sample majority vote and
// falling-edge detect on the synchronised line. Everything resets to idle-high.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic bit_maj,
  output logic fall_edge
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  // hist_q[0] is the previous synchronised sample, sync_q[1] the current one.
  assign fall_edge = hist_q[0] & ~sync_q[1];
  assign bit_maj   = maj3(hist_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with valid/ready output, frame_err and overrun
// pulses. Define PARITY_EN to receive 8E1 frames and report parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  logic bit_maj;
  logic fall_edge;

  uart_rx_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .bit_maj   (bit_maj),
    .fall_edge (fall_edge)
  );

  rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     load;
  logic                     stop_bad;
  logic                     half_tick;
  logic                     bit_tick;

  assign half_tick = (cnt_q == CNT_W'(HALF_BIT - 1));
  assign bit_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

`ifdef PARITY_EN
  logic par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    load     = 1'b0;
    stop_bad = 1'b0;
`ifdef PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = bit_maj ? IDLE : DATA;  // high at mid-start is a glitch
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_maj;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = bit_maj;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_maj) begin
            load = 1'b1;
            // a start edge already arriving in the stop bit is taken at once
            state_d = fall_edge ? START : IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (bit_maj) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: a new byte always wins; overrun only if the old byte
  // was neither accepted earlier nor in this very cycle.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    overrun_d   = 1'b0;
    frame_err_d = stop_bad;
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_ready;
    end
  end

`ifdef PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= load & (par_q != (^shift_q));
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=8; honours PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 8;
  localparam int H = C / 2;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT = 3 + H + (FRAME_BITS - 1) * C;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         rise_cnt = 0;
  int         busy_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] rise_data [0:63];
  int         rise_cyc  [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (busy)       busy_cnt <= busy_cnt + 1;
    if (rx_valid && !valid_prev) begin
      rise_data[rise_cnt[5:0]] <= rx_data;
      rise_cyc[rise_cnt[5:0]]  <= cyc;
      rise_cnt                 <= rise_cnt + 1;
    end
    valid_prev <= rx_valid;
  end

  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rx_i = v;
    repeat (C - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int start_cyc);
    @(posedge clk);
    #1 rx_i = 1'b0;
    start_cyc = cyc;
    repeat (C - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_v);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", rx_valid); end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    int r0, f0, s0, s1, lat0, lat1;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    f0 = fe_cnt + ov_cnt + pe_cnt;
    send_frame(8'h55, 1'b1, s0);
    send_frame(8'hA5, 1'b1, s1);
    idle(2 * C);
    lat0 = rise_cyc[r0[5:0]] - s0;
    lat1 = rise_cyc[r0[5:0] + 6'd1] - s1;
    checks++; if (rise_cnt - r0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", rise_cnt - r0); end
    checks++; if (rise_data[r0[5:0]] !== 8'h55) begin errors++; $display("FAIL b2b_byte0: got %h expected 55", rise_data[r0[5:0]]); end
    checks++; if (rise_data[r0[5:0] + 6'd1] !== 8'hA5) begin errors++; $display("FAIL b2b_byte1: got %h expected a5", rise_data[r0[5:0] + 6'd1]); end
    checks++; if (lat0 < LAT - 1 || lat0 > LAT + 1) begin errors++; $display("FAIL b2b_latency0: got %0d expected %0d+-1", lat0, LAT); end
    checks++; if (lat1 < LAT - 1 || lat1 > LAT + 1) begin errors++; $display("FAIL b2b_latency1: got %0d expected %0d+-1", lat1, LAT); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt - f0 != 0) begin errors++; $display("FAIL b2b_flags: got %0d pulses expected 0", fe_cnt + ov_cnt + pe_cnt - f0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_cleared: got %b expected 0", rx_valid); end
    $display("test_back_to_back: bytes %h %h latency %0d %0d", rise_data[r0[5:0]], rise_data[r0[5:0] + 6'd1], lat0, lat1);
  endtask

  task automatic test_overrun();
    int r0, o0, f0, s;
    rx_ready = 1'b0;
    r0 = rise_cnt;
    o0 = ov_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b1, s);
    send_frame(8'hC3, 1'b1, s);
    idle(C);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL ovr_data: got %h expected c3", rx_data); end
    checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - o0); end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL ovr_valid_rises: got %0d expected 1", rise_cnt - r0); end
    checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL ovr_frame_err: got %0d expected 0", fe_cnt - f0); end
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_clears: got %b expected 0", rx_valid); end
    $display("test_overrun: data %h overrun pulses %0d", rx_data, ov_cnt - o0);
  endtask

  task automatic test_glitch();
    int r0, f0, b0;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    f0 = fe_cnt + ov_cnt + pe_cnt;
    b0 = busy_cnt;
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_i = 1'b1;
    idle(4 * C);
    checks++; if (busy_cnt - b0 == 0) begin errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles expected 1..%0d", H + 3); end
    checks++; if (busy_cnt - b0 > H + 3) begin errors++; $display("FAIL glitch_busy_len: got %0d expected <= %0d", busy_cnt - b0, H + 3); end
    checks++; if (rise_cnt - r0 != 0) begin errors++; $display("FAIL glitch_valid: got %0d rises expected 0", rise_cnt - r0); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt - f0 != 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b expected 0", busy); end
    $display("test_glitch: busy cycles %0d", busy_cnt - b0);
  endtask

  task automatic test_break();
    int r0, f0, s;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_frame(8'h81, 1'b0, s);
    repeat (30 * C) @(posedge clk);
    #1 rx_i = 1'b1;
    idle(2 * C);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_frame_err: got %0d expected 1", fe_cnt - f0); end
    checks++; if (rise_cnt - r0 != 0) begin errors++; $display("FAIL break_valid: got %0d rises expected 0", rise_cnt - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release_idle: got busy %b expected 0", busy); end
    send_frame(8'h7E, 1'b1, s);
    idle(2 * C);
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL break_next_valid: got %0d rises expected 1", rise_cnt - r0); end
    checks++; if (rise_data[r0[5:0]] !== 8'h7E) begin errors++; $display("FAIL break_next_data: got %h expected 7e", rise_data[r0[5:0]]); end
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_single_err: got %0d expected 1", fe_cnt - f0); end
    $display("test_break: frame_err pulses %0d next byte %h", fe_cnt - f0, rise_data[r0[5:0]]);
  endtask

  task automatic test_spike();
    int r0, f0;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    f0 = fe_cnt + ov_cnt + pe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    // bit 3: one-cycle high spike inside the sampling window
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_i = 1'b1;
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (C - 5) @(posedge clk);
    for (int i = 4; i < 8; i++) drive_bit(1'b0);
`ifdef PARITY_EN
    drive_bit(1'b0);
`endif
    drive_bit(1'b1);
    idle(2 * C);
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL spike_valid: got %0d rises expected 1", rise_cnt - r0); end
    checks++; if (rise_data[r0[5:0]] !== 8'h00) begin errors++; $display("FAIL spike_data: got %h expected 00", rise_data[r0[5:0]]); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt - f0 != 0) begin errors++; $display("FAIL spike_flags: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt - f0); end
    $display("test_spike: data %h", rise_data[r0[5:0]]);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int r0, p0, f0;
    logic [7:0] b;
    b = 8'h07;
    rx_ready = 1'b0;
    r0 = rise_cnt;
    p0 = pe_cnt;
    f0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b0);  // odd parity: even-parity bit for 0x07 would be 1
    drive_bit(1'b1);
    idle(C);
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL parity_valid_rise: got %0d expected 1", rise_cnt - r0); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL parity_data: got %h expected 07", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL parity_valid: got %b expected 1", rx_valid); end
    checks++; if (pe_cnt - p0 != 1) begin errors++; $display("FAIL parity_err_pulses: got %0d expected 1", pe_cnt - p0); end
    checks++; if (fe_cnt - f0 != 0) begin errors++; $display("FAIL parity_frame_err: got %0d expected 0", fe_cnt - f0); end
    $display("test_parity: data %h parity_err pulses %0d", rx_data, pe_cnt - p0);
  endtask
`else
  task automatic test_parity();
    checks++; if (pe_cnt != 0) begin errors++; $display("FAIL parity_tied_low: got %0d pulses expected 0", pe_cnt); end
    $display("test_parity: parity_err pulses %0d", pe_cnt);
  endtask
`endif

  task automatic test_reset_mid();
    int s, f0;
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, s);
    idle(C);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL rmid_preload: got valid %b data %h expected 1 5a", rx_valid, rx_data); end
    f0 = fe_cnt + ov_cnt + pe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", rx_data); end
    checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b expected 000", {frame_err, overrun, parity_err}); end
    rx_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4 * C);
    checks++; if (fe_cnt + ov_cnt + pe_cnt - f0 != 0) begin errors++; $display("FAIL rmid_no_pulses: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt - f0); end
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_after: got busy %b valid %b expected 0 0", busy, rx_valid); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_break();
    test_spike();
    test_parity();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
